soc_bus_fabric: RTL and testbench
=================================

Name: soc_bus_fabric

Overview:
Parametrised memory-mapped interconnect between the FemtoRV32 data port and N slave slots; generalises the SoC's hard-wired chip-select decoder and read mux. Page-based address decode onto a one-hot chip select. Registered read-data mux. Real wait-state handshake drives mem_rbusy/mem_wbusy instead of tying them low. Per-transaction timeout with a sticky bus-error record. Slot 0 is program RAM and the default target; slots 1..N-1 are peripherals (uart, sqrt, mult, div, ...).

Parameters:
N_SLV, 8, number of slave slots (2..16); slot 0 = RAM
SEL_HI, 31, MSB of page field in mem_addr
SEL_LO, 16, LSB of page field
RAM_PAGE, 16'h0000, page decoding to slot 0
PER_BASE, 16'h0040, page of slot 1; slot k decodes at PER_BASE+k-1
TIMEOUT, 15, max wait cycles before bus error (>=1)
ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  synchronous, active-low reset
mem_addr  in  32  CPU byte address
mem_wdata  in  32  CPU write data
mem_wmask  in  4  CPU byte-write mask; nonzero = write request
mem_rstrb  in  1  CPU read strobe
mem_rdata  out  32  registered read data to CPU
mem_rbusy  out  1  read in progress
mem_wbusy  out  1  write in progress
cs  out  N_SLV  one-hot slave select
rd  out  1  read pulse to slaves
wr  out  1  write pulse to slaves
slv_wmask  out  4  mem_wmask gated by cs
slv_wdata  out  32  mem_wdata pass-through
slv_rdata  in  32*N_SLV  slave read data, slot k at [32k+31:32k]
slv_ready  in  N_SLV  slave k done (tie high for single-cycle slaves)
err_clr  in  1  clears sticky error
bus_err  out  1  sticky timeout flag
bus_err_addr  out  32  address of first timed-out access

Behaviour:
- Decode: page = mem_addr[SEL_HI:SEL_LO]; RAM_PAGE -> slot 0; PER_BASE+k-1 (1<=k<N_SLV) -> slot k; any other page -> slot 0.
- FSM states IDLE, RD_WAIT, WR_WAIT. Reset -> IDLE.
- In IDLE, cs is decoded combinationally from mem_addr. In wait states, cs = one-hot of latched index sel_q.
- rd = mem_rstrb & IDLE. wr = (|mem_wmask) & IDLE. slv_wmask = mem_wmask when wr, else 0.
- Strobe in cycle T (IDLE):
  - Latch sel_q and addr_q; clear the timeout counter.
  - Go to RD_WAIT (read) or WR_WAIT (write).
  - If rstrb and wmask are both set, the write wins and the read is dropped.
- mem_rbusy = (state==RD_WAIT); mem_wbusy = (state==WR_WAIT). Both are low at T; the CPU samples them from T+1.
- RD_WAIT, slv_ready[sel_q]=1 in cycle T+k: mem_rdata <= slot sel_q data; IDLE at T+k+1; data valid while rbusy is low. A ready slave gives 1 wait cycle (rbusy high only in T+1).
- WR_WAIT, ready: go to IDLE; nothing is registered.
- Timeout: each wait cycle without ready increments the counter. When it equals TIMEOUT:
  - Read: mem_rdata <= ERR_DATA. Write: discarded.
  - bus_err <= 1. bus_err_addr <= addr_q, only if bus_err was 0 (first error kept).
  - Go to IDLE.
- err_clr clears bus_err and bus_err_addr to 0. If it coincides with a new timeout, the set wins and addr_q is recorded.
- Strobes during RD_WAIT/WR_WAIT are ignored; rd/wr stay low.
- mem_rdata holds its value until the next read completes.
- Reset, including mid-transaction: state IDLE, mem_rdata=0, bus_err=0, bus_err_addr=0, counter=0, sel_q=0. Outputs rbusy/wbusy/rd/wr are 0 while resetn=0.

Test Plan:
- Read at 0x0042_0008, slot 3 ready tied high, slv_rdata slot3=0x1234_5678 -> cs=0x08 at T, rd=1 at T only, rbusy high T+1, mem_rdata=0x1234_5678 at T+2.
- Read at 0x0040_0000, slot 1 ready after 4 cycles -> rbusy high T+1..T+5, cs stays 0x02 while mem_addr changes, data valid at T+6.
- Write 0x0000_0010 with wmask=4'b0011 -> cs=0x01, slv_wmask=0011 at T only, wr=1 at T, wbusy high one cycle; read at unmapped 0x0099_0000 -> slot 0 selected.
- Read at 0x0041_0004, slot 2 ready never asserted, TIMEOUT=15 -> rbusy high 15 cycles, mem_rdata=0xDEAD_BEEF, bus_err=1, bus_err_addr=0x0041_0004; a second timeout at 0x0043_0000 leaves bus_err_addr unchanged; err_clr clears both.
- mem_rstrb and wmask=4'hF together -> only wr pulses, state WR_WAIT; err_clr concurrent with a timeout -> bus_err=1.
- resetn low mid RD_WAIT -> next cycle IDLE, rbusy=0, mem_rdata=0; a subsequent read completes normally.

Source files
------------

// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric: memory-mapped interconnect between the FemtoRV32 data port
// and N_SLV slave slots. Page decode onto a one-hot chip select, registered
// read mux, wait-state handshake and per-transaction timeout with a sticky
// bus-error record.
module soc_bus_fabric #(
  parameter int unsigned            N_SLV    = 8,
  parameter int unsigned            SEL_HI   = 31,
  parameter int unsigned            SEL_LO   = 16,
  parameter logic [SEL_HI-SEL_LO:0] RAM_PAGE = 16'h0000,
  parameter logic [SEL_HI-SEL_LO:0] PER_BASE = 16'h0040,
  parameter int unsigned            TIMEOUT  = 15,
  parameter logic [31:0]            ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  input  logic [3:0]           mem_wmask,
  input  logic                 mem_rstrb,
  output logic [31:0]          mem_rdata,
  output logic                 mem_rbusy,
  output logic                 mem_wbusy,
  output logic [N_SLV-1:0]     cs,
  output logic                 rd,
  output logic                 wr,
  output logic [3:0]           slv_wmask,
  output logic [31:0]          slv_wdata,
  input  logic [32*N_SLV-1:0]  slv_rdata,
  input  logic [N_SLV-1:0]     slv_ready,
  input  logic                 err_clr,
  output logic                 bus_err,
  output logic [31:0]          bus_err_addr
);

  localparam int unsigned PW = SEL_HI - SEL_LO + 1;
  localparam int unsigned IW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t        state, state_d;
  logic [IW-1:0] sel_q, dec_idx, cur_idx;
  logic [31:0]   addr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] page;
  logic [31:0]   sel_rdata;
  logic          sel_ready;
  logic          rd_done;
  logic          tmo;

  assign slv_wdata = mem_wdata;
  assign mem_rbusy = resetn && (state == RD_WAIT);
  assign mem_wbusy = resetn && (state == WR_WAIT);

  // Page decode: RAM page and any unmapped page fall through to slot 0.
  always_comb begin
    page    = mem_addr[SEL_HI:SEL_LO];
    dec_idx = '0;
    if (page != RAM_PAGE) begin
      for (int unsigned k = 1; k < N_SLV; k++) begin
        if (page == PER_BASE + PW'(k - 1)) dec_idx = IW'(k);
      end
    end
  end

  // Chip select follows the live address in IDLE, the latched slot while waiting.
  always_comb begin
    cur_idx = (state == IDLE) ? dec_idx : sel_q;
    cs      = '0;
    for (int unsigned k = 0; k < N_SLV; k++) begin
      cs[k] = (cur_idx == IW'(k));
    end
  end

  // Read data and ready of the latched slot.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    for (int unsigned k = 0; k < N_SLV; k++) begin
      if (sel_q == IW'(k)) begin
        sel_rdata = slv_rdata[32*k +: 32];
        sel_ready = slv_ready[k];
      end
    end
  end

  // Next-state, strobes and timeout detection; a write strobe beats a read.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt_q;
    rd        = 1'b0;
    wr        = 1'b0;
    slv_wmask = '0;
    rd_done   = 1'b0;
    tmo       = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (resetn) begin
          wr = |mem_wmask;
          rd = mem_rstrb & ~wr;
          if (wr) begin
            slv_wmask = mem_wmask;
            state_d   = WR_WAIT;
          end else if (rd) begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (sel_ready) begin
          state_d = IDLE;
          rd_done = (state == RD_WAIT);
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          tmo     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and wait counter register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt_q <= '0;
    end else begin
      state <= state_d;
      cnt_q <= cnt_d;
    end
  end

  // Transaction latch, read-data register and sticky error record.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sel_q        <= '0;
      addr_q       <= '0;
      mem_rdata    <= '0;
      bus_err      <= 1'b0;
      bus_err_addr <= '0;
    end else begin
      if (state == IDLE && state_d != IDLE) begin
        sel_q  <= dec_idx;
        addr_q <= mem_addr;
      end
      if (rd_done) begin
        mem_rdata <= sel_rdata;
      end else if (tmo && state == RD_WAIT) begin
        mem_rdata <= ERR_DATA;
      end
      // A timeout coinciding with err_clr counts as a fresh first error.
      if (tmo) begin
        bus_err <= 1'b1;
        if (!bus_err || err_clr) bus_err_addr <= addr_q;
      end else if (err_clr) begin
        bus_err      <= 1'b0;
        bus_err_addr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Self-checking bench for soc_bus_fabric: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_soc_bus_fabric;

  localparam int N  = 8;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           resetn;
  logic [31:0]    mem_addr, mem_wdata, mem_rdata, slv_wdata, bus_err_addr;
  logic [3:0]     mem_wmask, slv_wmask;
  logic           mem_rstrb, mem_rbusy, mem_wbusy, rd, wr, err_clr, bus_err;
  logic [N-1:0]   cs, slv_ready;
  logic [32*N-1:0] slv_rdata;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] exp_rdata    = '0;
  logic        exp_err      = 1'b0;
  logic [31:0] exp_err_addr = '0;

  always #5 clk = ~clk;

  soc_bus_fabric #(
    .N_SLV   (N),
    .SEL_HI  (31),
    .SEL_LO  (16),
    .RAM_PAGE(16'h0000),
    .PER_BASE(16'h0040),
    .TIMEOUT (TO),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wmask   (mem_wmask),
    .mem_rstrb   (mem_rstrb),
    .mem_rdata   (mem_rdata),
    .mem_rbusy   (mem_rbusy),
    .mem_wbusy   (mem_wbusy),
    .cs          (cs),
    .rd          (rd),
    .wr          (wr),
    .slv_wmask   (slv_wmask),
    .slv_wdata   (slv_wdata),
    .slv_rdata   (slv_rdata),
    .slv_ready   (slv_ready),
    .err_clr     (err_clr),
    .bus_err     (bus_err),
    .bus_err_addr(bus_err_addr)
  );

  // Reference decode: page 0x40..0x46 maps to slots 1..7, everything else to RAM.
  function automatic int ref_slot(input logic [31:0] a);
    int pg;
    pg = int'(a[31:16]);
    if (pg >= 'h40 && pg < 'h40 + N - 1) return pg - 'h40 + 1;
    return 0;
  endfunction

  // One complete transaction: strobe cycle, lat-limited wait cycles, completion.
  task automatic do_txn(input string tag, input logic [31:0] addr, input logic rs,
                        input logic [3:0] wm, input int unsigned lat, input logic clr);
    int          slot;
    int unsigned n;
    logic        is_wr, is_rd, timed;
    logic [N-1:0] exp_cs;
    logic [31:0] word;
    slot   = ref_slot(addr);
    is_wr  = |wm;
    is_rd  = rs & ~is_wr;
    exp_cs = '0;
    exp_cs[slot] = 1'b1;
    timed  = (lat > TO);
    n      = timed ? TO : lat;

    @(negedge clk);
    mem_addr  = addr;
    mem_rstrb = rs;
    mem_wmask = wm;
    mem_wdata = $urandom;
    err_clr   = 1'b0;
    slv_ready = N'($urandom);
    for (int k = 0; k < N; k++) slv_rdata[32*k +: 32] = $urandom;
    word = slv_rdata[32*slot +: 32];
    #1;
    total_cnt++;
    if (cs !== exp_cs) $display("FAIL %s cs_strobe: got %h expected %h", tag, cs, exp_cs);
    else pass_cnt++;
    total_cnt++;
    if ({rd, wr} !== {is_rd, is_wr})
      $display("FAIL %s rd_wr_strobe: got %b expected %b", tag, {rd, wr}, {is_rd, is_wr});
    else pass_cnt++;
    total_cnt++;
    if ({slv_wmask, slv_wdata} !== {wm, mem_wdata})
      $display("FAIL %s wmask_wdata: got %h expected %h", tag, {slv_wmask, slv_wdata}, {wm, mem_wdata});
    else pass_cnt++;
    total_cnt++;
    if ({mem_rbusy, mem_wbusy} !== 2'b00)
      $display("FAIL %s busy_strobe: got %b expected 00", tag, {mem_rbusy, mem_wbusy});
    else pass_cnt++;

    for (int unsigned j = 1; j <= n; j++) begin
      @(negedge clk);
      mem_addr  = $urandom;
      mem_rstrb = 1'($urandom);
      mem_wmask = 4'($urandom);
      slv_ready = N'($urandom);
      slv_ready[slot] = (j >= lat);
      err_clr   = (j == n) ? clr : 1'b0;
      #1;
      total_cnt++;
      if ({mem_rbusy, mem_wbusy} !== {is_rd, is_wr})
        $display("FAIL %s busy_wait%0d: got %b expected %b", tag, j, {mem_rbusy, mem_wbusy}, {is_rd, is_wr});
      else pass_cnt++;
      total_cnt++;
      if (cs !== exp_cs) $display("FAIL %s cs_wait%0d: got %h expected %h", tag, j, cs, exp_cs);
      else pass_cnt++;
      total_cnt++;
      if ({rd, wr, slv_wmask} !== 6'b0)
        $display("FAIL %s strobe_ignored%0d: got %b expected 0", tag, j, {rd, wr, slv_wmask});
      else pass_cnt++;
    end

    if (is_rd) exp_rdata = timed ? 32'hDEAD_BEEF : word;
    if (timed) begin
      if (!exp_err || clr) exp_err_addr = addr;
      exp_err = 1'b1;
    end else if (clr) begin
      exp_err      = 1'b0;
      exp_err_addr = '0;
    end

    @(negedge clk);
    mem_rstrb = 1'b0;
    mem_wmask = '0;
    err_clr   = 1'b0;
    #1;
    total_cnt++;
    if ({mem_rbusy, mem_wbusy} !== 2'b00)
      $display("FAIL %s busy_done: got %b expected 00", tag, {mem_rbusy, mem_wbusy});
    else pass_cnt++;
    total_cnt++;
    if (mem_rdata !== exp_rdata) $display("FAIL %s rdata: got %h expected %h", tag, mem_rdata, exp_rdata);
    else pass_cnt++;
    total_cnt++;
    if ({bus_err, bus_err_addr} !== {exp_err, exp_err_addr})
      $display("FAIL %s bus_err: got %b/%h expected %b/%h", tag, bus_err, bus_err_addr, exp_err, exp_err_addr);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    resetn    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = 4'hF;
    mem_rstrb = 1'b1;
    err_clr   = 1'b0;
    slv_ready = '0;
    slv_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    total_cnt++;
    if ({mem_rbusy, mem_wbusy, rd, wr} !== 4'b0)
      $display("FAIL reset_strobes: got %b expected 0000", {mem_rbusy, mem_wbusy, rd, wr});
    else pass_cnt++;
    total_cnt++;
    if ({mem_rdata, bus_err, bus_err_addr} !== 65'b0)
      $display("FAIL reset_regs: got %h/%b/%h expected 0/0/0", mem_rdata, bus_err, bus_err_addr);
    else pass_cnt++;
    @(negedge clk);
    resetn    = 1'b1;
    mem_wmask = '0;
    mem_rstrb = 1'b0;
  endtask

  task automatic test_read_ready;
    do_txn("rd_slot3", 32'h0042_0008, 1'b1, 4'h0, 1, 1'b0);
  endtask

  task automatic test_read_wait;
    do_txn("rd_wait4", 32'h0040_0000, 1'b1, 4'h0, 5, 1'b0);
  endtask

  task automatic test_write;
    do_txn("wr_ram", 32'h0000_0010, 1'b0, 4'b0011, 1, 1'b0);
    do_txn("rd_unmapped", 32'h0099_0000, 1'b1, 4'h0, 1, 1'b0);
  endtask

  task automatic test_timeout;
    do_txn("tmo_first", 32'h0041_0004, 1'b1, 4'h0, 100, 1'b0);
    do_txn("tmo_second", 32'h0043_0000, 1'b1, 4'h0, 100, 1'b0);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    exp_err      = 1'b0;
    exp_err_addr = '0;
    total_cnt++;
    if ({bus_err, bus_err_addr} !== 33'b0)
      $display("FAIL err_clr: got %b/%h expected 0/0", bus_err, bus_err_addr);
    else pass_cnt++;
    do_txn("wr_tmo", 32'h0046_0020, 1'b0, 4'hF, 50, 1'b0);
  endtask

  task automatic test_both_strobes;
    do_txn("both_strobes", 32'h0044_0000, 1'b1, 4'hF, 2, 1'b0);
    do_txn("clr_vs_tmo", 32'h0045_0000, 1'b1, 4'h0, 100, 1'b1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      int unsigned r, kind, lat;
      logic [15:0] pg;
      logic [3:0]  wm;
      logic        rs, clr;
      r = $urandom_range(0, 9);
      if (r == 0) pg = 16'h0000;
      else if (r <= 7) pg = 16'h0040 + 16'(r - 1);
      else pg = 16'($urandom);
      kind = $urandom_range(0, 2);
      wm   = (kind != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      rs   = (kind != 1);
      lat  = $urandom_range(1, 20);
      clr  = ($urandom_range(0, 3) == 0);
      do_txn("random", {pg, 16'($urandom)}, rs, wm, lat, clr);
    end
  endtask

  task automatic test_reset_mid;
    do_txn("pre_reset", 32'h0042_0000, 1'b1, 4'h0, 1, 1'b0);
    @(negedge clk);
    mem_addr  = 32'h0041_0000;
    mem_rstrb = 1'b1;
    slv_ready = '0;
    @(negedge clk);
    mem_rstrb = 1'b0;
    #1;
    total_cnt++;
    if (mem_rbusy !== 1'b1) $display("FAIL mid_rbusy: got %b expected 1", mem_rbusy);
    else pass_cnt++;
    @(negedge clk);
    resetn    = 1'b0;
    mem_rstrb = 1'b1;
    #1;
    total_cnt++;
    if ({mem_rbusy, mem_wbusy, rd, wr} !== 4'b0)
      $display("FAIL mid_reset_out: got %b expected 0000", {mem_rbusy, mem_wbusy, rd, wr});
    else pass_cnt++;
    @(negedge clk);
    resetn    = 1'b1;
    mem_rstrb = 1'b0;
    #1;
    exp_rdata    = '0;
    exp_err      = 1'b0;
    exp_err_addr = '0;
    total_cnt++;
    if ({mem_rbusy, mem_rdata, bus_err, bus_err_addr} !== 66'b0)
      $display("FAIL after_reset: got %b/%h/%b/%h expected 0", mem_rbusy, mem_rdata, bus_err, bus_err_addr);
    else pass_cnt++;
    do_txn("post_reset", 32'h0040_0000, 1'b1, 4'h0, 3, 1'b0);
  endtask

  initial begin
    test_reset();
    test_read_ready();
    test_read_wait();
    test_write();
    test_timeout();
    test_both_strobes();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
